// File: rtl/fifo_pack_reader.sv
// Read-side FIFO consumer: pops WIDTH-bit elements and packs PACK of them into
// one wide word on a valid/ready stream; flush emits a partial word.
module fifo_pack_reader #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4,
  localparam int CW   = $clog2(PACK + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [WIDTH-1:0]      fifo_rdata,
  input  logic                  flush,
  output logic [WIDTH*PACK-1:0] out_data,
  output logic [CW-1:0]         out_count,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic {FILL, OUT} state_t;

  localparam logic [CW:0]   PACK_LEVEL = (CW + 1)'(PACK);
  localparam logic [CW-1:0] FULL       = CW'(PACK);
  localparam logic [CW-1:0] LAST       = CW'(PACK - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          pending;
  logic          flush_req;
  logic [CW:0]   level;

  // A pop already in flight reserves its lane, so count+pending caps new pops.
  always_comb begin
    level      = {1'b0, count} + {{CW{1'b0}}, pending};
    fifo_rd_en = !reset && (state == FILL) && !fifo_empty && !flush_req &&
                 (level < PACK_LEVEL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      count     <= '0;
      pending   <= 1'b0;
      flush_req <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      case (state)
        FILL: begin
          pending   <= fifo_rd_en;
          flush_req <= flush_req | flush;
          if (pending) begin
            for (int unsigned k = 0; k < PACK; k++) begin
              if (count == CW'(k)) out_data[k*WIDTH +: WIDTH] <= fifo_rdata;
            end
            count <= count + 1'b1;
            // Completing a word also satisfies any outstanding flush.
            if (count == LAST) begin
              state     <= OUT;
              out_valid <= 1'b1;
              out_count <= FULL;
              flush_req <= 1'b0;
            end
          end else if (flush_req) begin
            flush_req <= 1'b0;
            if (count != '0) begin
              state     <= OUT;
              out_valid <= 1'b1;
              out_count <= count;
            end
          end
        end
        OUT: begin
          pending <= 1'b0;
          if (out_ready) begin
            state     <= FILL;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
